// File: rtl/rf_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter and its scoreboard.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rf_wb_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;

    // Arbiter FSM: NORMAL lets the pipeline win, FORCE stalls it so the long unit drains.
    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_FORCE  = 1'b1
    } arb_state_e;

    // Which source owns the registered write-port contents.
    typedef enum logic {
        SRC_PIPE = 1'b0,
        SRC_LU   = 1'b1
    } src_e;

endpackage

// File: rtl/rf_wb_arbiter_scoreboard.sv
// Pending-destination bitmap for long-latency results, with two decode lookup ports.
// Latency: set/clear take effect at the next edge; lookups are combinational (no bypass).
// Backpressure: none; set and clear are accepted every cycle, set wins on a collision.
//
// Ports: clk/resetn; set_vld/set_addr (issue); clr_vld/clr_addr (long-unit write);
//        chk_addr1/chk_addr2 -> chk_busy1/chk_busy2.
module rf_scoreboard
    import rf_wb_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  set_vld,
    input  logic [REG_ADDR_W-1:0] set_addr,
    input  logic                  clr_vld,
    input  logic [REG_ADDR_W-1:0] clr_addr,
    input  logic [REG_ADDR_W-1:0] chk_addr1,
    input  logic [REG_ADDR_W-1:0] chk_addr2,
    output logic                  chk_busy1,
    output logic                  chk_busy2
);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_vld) set_mask[set_addr] = 1'b1;
        if (clr_vld) clr_mask[clr_addr] = 1'b1;
        // Clear first, then set: an issue landing on the same edge as the old
        // result's write must keep the register pending for the new result.
        pending_d    = (pending_q & ~clr_mask) | set_mask;
        // r0 is hardwired zero and can never be outstanding.
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) pending_q <= '0;
        else         pending_q <= pending_d;
    end

    assign chk_busy1 = pending_q[chk_addr1];
    assign chk_busy2 = pending_q[chk_addr2];

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the single register-file write port between pipeline writeback and a long-latency unit.
// Latency: 1 cycle from grant to rf_we/rf_waddr/rf_wdata; pipe_stall is registered FSM state.
// Backpressure: pipeline has priority; the long unit is refused via lu_ready and, after
//               STARVE_LIMIT refused cycles, the pipeline is stalled for one forced grant.
//
// Ports: clk/resetn; wb_* pipeline writeback; lu_* long-unit result with lu_ready;
//        iss_* pending-set on issue; chk_addr*/chk_busy* decode lookup; pipe_stall; rf_* write port.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 3
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0]     wb_data,
    input  logic                  lu_valid,
    input  logic [REG_ADDR_W-1:0] lu_addr,
    input  logic [DATA_W-1:0]     lu_data,
    output logic                  lu_ready,
    input  logic                  iss_valid,
    input  logic [REG_ADDR_W-1:0] iss_addr,
    input  logic [REG_ADDR_W-1:0] chk_addr1,
    input  logic [REG_ADDR_W-1:0] chk_addr2,
    output logic                  chk_busy1,
    output logic                  chk_busy2,
    output logic                  pipe_stall,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata
);

    localparam int              CNT_W    = (STARVE_LIMIT < 4) ? 2 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(STARVE_LIMIT - 1);

    arb_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic                  grant_vld;
    src_e                  grant_src;
    logic [REG_ADDR_W-1:0] grant_addr;
    logic [DATA_W-1:0]     grant_data;

    logic                  rf_we_q;
    logic [REG_ADDR_W-1:0] rf_waddr_q;
    logic [DATA_W-1:0]     rf_wdata_q;
    src_e                  src_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lu_ready   = 1'b0;
        grant_vld  = 1'b0;
        grant_src  = SRC_PIPE;
        grant_addr = wb_addr;
        grant_data = wb_data;

        unique case (state_q)
            ST_NORMAL: begin
                lu_ready = !wb_valid;
                if (wb_valid) begin
                    grant_vld = 1'b1;
                end else if (lu_valid) begin
                    grant_vld  = 1'b1;
                    grant_src  = SRC_LU;
                    grant_addr = lu_addr;
                    grant_data = lu_data;
                end
                // Only a refused result counts as starvation; a handshake or an
                // idle long unit restarts the count.
                if (lu_valid && wb_valid) begin
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LIMIT_M1) state_d = ST_FORCE;
                end else begin
                    cnt_d = '0;
                end
            end
            ST_FORCE: begin
                // Pipeline is stalled and keeps holding its writeback, so it is
                // safe to ignore wb_valid here.
                lu_ready = 1'b1;
                cnt_d    = '0;
                state_d  = ST_NORMAL;
                if (lu_valid) begin
                    grant_vld  = 1'b1;
                    grant_src  = SRC_LU;
                    grant_addr = lu_addr;
                    grant_data = lu_data;
                end
            end
            default: begin
                state_d = ST_NORMAL;
                cnt_d   = '0;
            end
        endcase

        // No handshake may be signalled while the block is held in reset.
        if (!resetn) lu_ready = 1'b0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_NORMAL;
            cnt_q      <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            src_q      <= SRC_PIPE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            // r0 writes are consumed (handshake done) but never reach the file.
            rf_we_q <= grant_vld && (grant_addr != '0);
            if (grant_vld) begin
                rf_waddr_q <= grant_addr;
                rf_wdata_q <= grant_data;
                src_q      <= grant_src;
            end
        end
    end

    assign pipe_stall = (state_q == ST_FORCE);
    assign rf_we      = rf_we_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;

    // Pending bit clears on the edge the long-unit write is presented, so decode
    // sees busy until the value is actually in the register file.
    rf_scoreboard u_scoreboard (
        .clk       (clk),
        .resetn    (resetn),
        .set_vld   (iss_valid),
        .set_addr  (iss_addr),
        .clr_vld   (rf_we_q && (src_q == SRC_LU)),
        .clr_addr  (rf_waddr_q),
        .chk_addr1 (chk_addr1),
        .chk_addr2 (chk_addr2),
        .chk_busy1 (chk_busy1),
        .chk_busy2 (chk_busy2)
    );

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 3, meaning the number of cycles long-unit result waits before the pipeline is forced to stall.
REQ-002 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-003 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports wb_valid/wb_addr/wb_data  input  1/5/32  pipeline writeback request; no ready, held by the pipeline while pipe_stall=1.
REQ-005 SHALL have ports lu_valid/lu_addr/lu_data  input  1/5/32  long-latency unit (mul/div/load-miss) result.
REQ-006 SHALL have port lu_ready  output  1  long-unit result accepted when lu_valid and lu_ready are both 1.
REQ-007 SHALL have ports iss_valid/iss_addr  input  1/5  long-unit issue; marks the destination register pending.
REQ-008 SHALL have ports chk_addr1/chk_addr2  input  5, and chk_busy1/chk_busy2  output  1  combinational pending lookup for decode.
REQ-009 SHALL have port pipe_stall  output  1  registered, and ports rf_we/rf_waddr/rf_wdata  output  1/5/32  registered, driving the register-file write port.

Function
REQ-010 SHALL implement FSM states NORMAL and FORCE; pipe_stall = (state==FORCE).
REQ-011 In NORMAL SHALL set lu_ready = !wb_valid; pipeline writeback has priority.
REQ-012 In FORCE SHALL set lu_ready=1 and ignore wb_valid; pipeline write is not lost because pipeline holds it.
REQ-013 Wait counter (2 bits min) SHALL increment each NORMAL cycle with lu_valid && wb_valid, saturating; clear on any lu handshake or !lu_valid.
REQ-014 NORMAL->FORCE SHALL occur at the edge where counter==STARVE_LIMIT-1 and lu_valid && wb_valid (i.e. after STARVE_LIMIT refused cycles).
REQ-015 FORCE->NORMAL SHALL occur on the edge of the lu handshake, or if lu_valid drops (protocol violation; recover, no write).
REQ-016 Granted source SHALL be registered into rf_we/rf_waddr/rf_wdata one cycle after grant (latency 1); rf_we=0 in cycles without grant.
REQ-017 Writes with address 0 SHALL be accepted (lu handshake still occurs) but rf_we SHALL stay 0.
REQ-018 Scoreboard SHALL hold a 32-bit pending bitmap; bit 0 never set.
REQ-019 iss_valid with iss_addr!=0 SHALL set the bit at the next edge.
REQ-020 Bit SHALL clear at the edge where rf_we=1 for that address with registered source = long unit (write then visible to reads).
REQ-021 Simultaneous set and clear of the same bit SHALL leave it set.
REQ-022 Pipeline writebacks SHALL NOT clear pending bits.
REQ-023 chk_busyN SHALL equal the pending bit of chk_addrN, 0 for address 0, no bypass of same-cycle iss_valid.

Reset
REQ-024 resetn low SHALL immediately force state=NORMAL, counter=0, bitmap=0, pipe_stall=0, rf_we=0, rf_waddr=0, rf_wdata=0.
REQ-025 lu_ready SHALL be 0 while resetn is low; reset during FORCE drops the in-flight result without writing.

Structure
REQ-026 Shared package SHALL hold REG_ADDR_W=5, DATA_W=32, the FSM state enum, and source encoding (SRC_PIPE, SRC_LU).
REQ-027 Scoreboard SHALL be sub-module rf_scoreboard (set port, clear port, two lookup ports); arbiter FSM and output register stay in the top.

Verification
REQ-028 lu_valid alone, lu_addr=7, data=0xDEADBEEF -> lu_ready=1 same cycle; next cycle rf_we=1, waddr=7, wdata=0xDEADBEEF.
REQ-029 wb_valid and lu_valid held 3 cycles -> lu_ready=0 for 3 cycles, pipe_stall=1 on cycle 4, lu granted, pipe_stall=0 the cycle after.
REQ-030 iss_valid addr=5, then lu result to 5 after 10 cycles -> chk_busy=1 from next cycle until the edge rf_we writes 5, then 0.
REQ-031 Clear of bit 9 and new iss_valid addr=9 same edge -> bit 9 remains set.
REQ-032 lu_addr=0 and wb_addr=0 -> handshake completes, rf_we never asserted, bit 0 never busy.
REQ-033 resetn pulsed low during FORCE with pending bits set -> all outputs 0 asynchronously, bitmap empty, NORMAL after release.
